// File: rtl/me_pkg.sv
// Shared sizes and the state encoding for the motion-estimator frame server.
package me_pkg;

    localparam int R_WORDS = 256;
    localparam int S_WORDS = 961;
    localparam int DW      = 8;
    localparam int R_AW    = 8;
    localparam int S_AW    = 10;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_R,
        LOAD_S,
        FIRE,
        SERVE
    } meState_e;

endpackage

// File: rtl/me_byte_ram.sv
// Synchronous byte RAM with one write port and NRD registered read ports.
// A read address at or beyond DEPTH returns 0, and a read that hits the
// address being written in the same cycle returns the old contents.
module me_byte_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int DW    = 8,
    parameter int NRD   = 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    we,
    input  logic [AW-1:0]           waddr,
    input  logic [DW-1:0]           wdata,
    input  logic [NRD-1:0][AW-1:0]  raddr,
    output logic [NRD-1:0][DW-1:0]  rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Storage write; deliberately unaffected by reset so contents survive an abort
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read ports, zeroed on reset and for out-of-range addresses
    always_ff @(posedge clock) begin
        if (reset) begin
            rdata <= '0;
        end else begin
            for (int i = 0; i < NRD; i++) begin
                if (32'(raddr[i]) < DEPTH) begin
                    rdata[i] <= mem[raddr[i]];
                end else begin
                    rdata[i] <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/me_frame_server.sv
// Frame-memory responder: loads a reference block and a search window from a
// byte stream, pulses start, then serves estimator reads with 1-cycle latency.
import me_pkg::*;

module me_frame_server #(
    parameter int R_WORDS = me_pkg::R_WORDS,
    parameter int S_WORDS = me_pkg::S_WORDS,
    parameter int DW      = me_pkg::DW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load_req,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          start,
    output logic          busy,
    input  logic [7:0]    AddressR,
    input  logic [9:0]    AddressS1,
    input  logic [9:0]    AddressS2,
    output logic [DW-1:0] R,
    output logic [DW-1:0] s1,
    output logic [DW-1:0] s2,
    output logic          addr_err
);

    meState_e               state;
    logic [9:0]             cnt;
    logic                   inReady;
    logic                   handshake;
    logic                   rWriteEn;
    logic                   sWriteEn;
    logic                   searchOob;
    logic [1:0][9:0]        sReadAddr;
    logic [1:0][DW-1:0]     sReadData;

    assign handshake = in_valid & inReady;
    assign rWriteEn  = handshake && (state == LOAD_R);
    assign sWriteEn  = handshake && (state == LOAD_S);
    assign searchOob = (AddressS1 >= 10'(S_WORDS)) || (AddressS2 >= 10'(S_WORDS));
    assign sReadAddr = {AddressS2, AddressS1};
    assign in_ready  = inReady;
    assign s1        = sReadData[0];
    assign s2        = sReadData[1];

    me_byte_ram #(
        .DEPTH (R_WORDS),
        .AW    (8),
        .DW    (DW),
        .NRD   (1)
    ) refRam (
        .clock (clock),
        .reset (reset),
        .we    (rWriteEn),
        .waddr (cnt[7:0]),
        .wdata (in_data),
        .raddr (AddressR),
        .rdata (R)
    );

    me_byte_ram #(
        .DEPTH (S_WORDS),
        .AW    (10),
        .DW    (DW),
        .NRD   (2)
    ) searchRam (
        .clock (clock),
        .reset (reset),
        .we    (sWriteEn),
        .waddr (cnt),
        .wdata (in_data),
        .raddr (sReadAddr),
        .rdata (sReadData)
    );

    // Load/serve sequencer with registered in_ready, busy, start and addr_err
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            inReady  <= 1'b0;
            busy     <= 1'b0;
            start    <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            start <= 1'b0;
            case (state)
                IDLE, SERVE: begin
                    if (load_req) begin
                        state    <= LOAD_R;
                        cnt      <= '0;
                        inReady  <= 1'b1;
                        busy     <= 1'b1;
                        addr_err <= 1'b0;
                    end else if (state == SERVE && searchOob) begin
                        addr_err <= 1'b1;
                    end
                end
                LOAD_R: begin
                    if (handshake) begin
                        if (cnt == 10'(R_WORDS - 1)) begin
                            state <= LOAD_S;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 10'd1;
                        end
                    end
                end
                LOAD_S: begin
                    if (handshake) begin
                        if (cnt == 10'(S_WORDS - 1)) begin
                            state   <= FIRE;
                            start   <= 1'b1;
                            inReady <= 1'b0;
                        end else begin
                            cnt <= cnt + 10'd1;
                        end
                    end
                end
                FIRE: begin
                    state <= SERVE;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    inReady <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_me_frame_server.sv
// Directed self-checking bench for me_frame_server.
module tb_me_frame_server;

    logic       clock = 1'b0;
    logic       reset;
    logic       load_req;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       start;
    logic       busy;
    logic [7:0] AddressR;
    logic [9:0] AddressS1;
    logic [9:0] AddressS2;
    logic [7:0] R;
    logic [7:0] s1;
    logic [7:0] s2;
    logic       addr_err;

    int assertCount = 0;
    int failCount   = 0;
    int startSeen   = 0;
    int hsCount     = 0;
    int flagCount   = 0;

    localparam int TOTAL = 1217;

    me_frame_server dut (
        .clock     (clock),
        .reset     (reset),
        .load_req  (load_req),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .start     (start),
        .busy      (busy),
        .AddressR  (AddressR),
        .AddressS1 (AddressS1),
        .AddressS2 (AddressS2),
        .R         (R),
        .s1        (s1),
        .s2        (s2),
        .addr_err  (addr_err)
    );

    always #5 clock = ~clock;

    // One comparison: counts, asserts and reports a failing tag
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
            $error("[TB] assertion violated at %s", tag);
        end
    endtask

    // Streams bytes k mod 256 until 'limit' handshakes or the cycle budget runs out
    task automatic applyStimulus(input bit randomValid, input int limit);
        int cycles = 0;
        hsCount = 0;
        while (hsCount < limit && cycles < 8000) begin
            if (start) startSeen++;
            in_valid = randomValid ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data  = 8'(hsCount);
            if (in_valid && in_ready) hsCount++;
            @(negedge clock);
            cycles++;
        end
        in_valid = 1'b0;
        checkOutput("load_budget", hsCount, limit);
    endtask

    // Accepted load request; a byte offered in the same cycle must be ignored
    task automatic pulseLoad();
        load_req = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hAA;
        @(negedge clock);
        load_req = 1'b0;
        in_valid = 1'b0;
    endtask

    // End-of-load checks: start exactly one cycle after the last handshake
    task automatic checkLoadEnd(input string tag);
        checkOutput({tag, "_start_early"}, startSeen, 0);
        checkOutput({tag, "_start_pulse"}, start, 1'b1);
        checkOutput({tag, "_inready_drop"}, in_ready, 1'b0);
        @(negedge clock);
        checkOutput({tag, "_start_once"}, start, 1'b0);
        checkOutput({tag, "_busy_low"}, busy, 1'b0);
        repeat (3) begin
            @(negedge clock);
            if (start) startSeen++;
        end
        checkOutput({tag, "_no_restart"}, startSeen, 0);
    endtask

    // Presents read addresses and checks the data registered one edge later
    task automatic readCheck(input string tag, input logic [7:0] ar, input logic [9:0] a1, input logic [9:0] a2,
                             input logic [7:0] er, input logic [7:0] e1, input logic [7:0] e2);
        AddressR  = ar;
        AddressS1 = a1;
        AddressS2 = a2;
        @(negedge clock);
        checkOutput({tag, "_R"}, R, er);
        checkOutput({tag, "_s1"}, s1, e1);
        checkOutput({tag, "_s2"}, s2, e2);
    endtask

    initial begin
        $display("[TB] starting me_frame_server bench");
        reset     = 1'b1;
        load_req  = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        AddressR  = 8'd0;
        AddressS1 = 10'd0;
        AddressS2 = 10'd0;
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Reset state
        checkOutput("rst_R", R, 8'd0);
        checkOutput("rst_s1", s1, 8'd0);
        checkOutput("rst_s2", s2, 8'd0);
        checkOutput("rst_start", start, 1'b0);
        checkOutput("rst_inready", in_ready, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_adderr", addr_err, 1'b0);

        // Idle 10 cycles: no start, never ready
        flagCount = 0;
        repeat (10) begin
            @(negedge clock);
            if (start || in_ready || busy) flagCount++;
        end
        checkOutput("idle_quiet", flagCount, 0);

        // Full load with continuous valid
        pulseLoad();
        checkOutput("load_ready", in_ready, 1'b1);
        checkOutput("load_busy", busy, 1'b1);
        startSeen = 0;
        applyStimulus(1'b0, TOTAL);
        checkLoadEnd("load1");

        // Reads after load
        readCheck("rd_a", 8'd5, 10'd300, 10'd960, 8'd5, 8'd44, 8'd192);
        readCheck("rd_b", 8'd255, 10'd17, 10'd17, 8'd255, 8'd17, 8'd17);
        checkOutput("rd_adderr", addr_err, 1'b0);

        // Out-of-range on port 2 in SERVE
        readCheck("oob", 8'd0, 10'd960, 10'd1000, 8'd0, 8'd192, 8'd0);
        checkOutput("oob_flag", addr_err, 1'b1);
        readCheck("oob_after", 8'd1, 10'd0, 10'd5, 8'd1, 8'd0, 8'd5);
        checkOutput("oob_sticky", addr_err, 1'b1);

        // Backpressure load; load_req clears the flag
        pulseLoad();
        checkOutput("bp_adderr_clr", addr_err, 1'b0);
        startSeen = 0;
        applyStimulus(1'b1, TOTAL);
        checkLoadEnd("bp");
        readCheck("bp_rd_a", 8'd0, 10'd0, 10'd500, 8'd0, 8'd0, 8'd244);
        readCheck("bp_rd_b", 8'd200, 10'd959, 10'd1, 8'd200, 8'd191, 8'd1);

        // Abort after 100 search-window bytes
        pulseLoad();
        startSeen = 0;
        applyStimulus(1'b0, 356);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("abort_R", R, 8'd0);
        checkOutput("abort_inready", in_ready, 1'b0);
        checkOutput("abort_busy", busy, 1'b0);
        repeat (10) begin
            @(negedge clock);
            if (start) startSeen++;
        end
        checkOutput("abort_no_start", startSeen, 0);
        readCheck("abort_mem_kept", 8'd5, 10'd960, 10'd2, 8'd5, 8'd192, 8'd2);

        // Full load after the abort
        pulseLoad();
        startSeen = 0;
        applyStimulus(1'b0, TOTAL);
        checkLoadEnd("reload");
        readCheck("reload_rd", 8'd77, 10'd300, 10'd960, 8'd77, 8'd44, 8'd192);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
